// File: rtl/fft_ring_gather_node.sv
// fft_ring_gather_node: multi-channel FFT message-ring node.
// Forwards/terminates ring traffic and gathers watched points into slots.
module fft_ring_gather_node #(
  parameter int NCHAN = 2,
  parameter int ID_W = 32,
  parameter int PT_W = 32,
  parameter logic [ID_W-1:0] NODEID = '0,
  parameter int NWATCH = 3,
  parameter logic [NWATCH*ID_W-1:0] NIDS = '0,
  parameter int NPBUFFS = 2,
  parameter logic [NCHAN*ID_W-1:0] MD_STOP_SRC = '0,
  parameter logic [NCHAN*ID_W-1:0] OD_STOP_SRC = '0,
  parameter logic [NCHAN-1:0] TYPE_RST = '0,
  parameter logic [NCHAN-1:0] SEED = '0,
  parameter int ERR_W = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic gen_en,
  input  logic [NCHAN-1:0] rx_vld,
  input  logic [NCHAN-1:0] rx_type,
  input  logic [NCHAN*ID_W-1:0] rx_src,
  input  logic [NCHAN*PT_W-1:0] rx_pt,
  output logic [NCHAN-1:0] tx_vld,
  output logic [NCHAN-1:0] tx_type,
  output logic [NCHAN*ID_W-1:0] tx_src,
  output logic [NCHAN*PT_W-1:0] tx_pt,
  output logic out_vld,
  input  logic out_rdy,
  output logic [$clog2(NPBUFFS)-1:0] out_slot,
  output logic [PT_W-1:0] out_pt,
  output logic err,
  output logic [ERR_W-1:0] err_cnt
);

  localparam int SW = $clog2(NPBUFFS);
  localparam logic [PT_W-1:0] PT_ONE = 1;
  localparam logic [ERR_W-1:0] E_ONE = 1;

  logic [NCHAN-1:0] hit;
  logic [NCHAN-1:0] ltype;
  logic [PT_W-1:0] cnt [NCHAN];

  logic [NWATCH-1:0] sv [NPBUFFS];
  logic [NWATCH-1:0] sv_n [NPBUFFS];
  logic [PT_W-1:0] sd [NPBUFFS][NWATCH];
  logic [PT_W-1:0] sd_n [NPBUFFS][NWATCH];

  logic err_n;
  logic [ERR_W-1:0] ecnt_n;
  logic pop;
  logic found;
  logic [SW-1:0] sel;

  assign pop = out_vld && out_rdy;

  // Stop-source match per channel, source chosen by message type
  always_comb begin
    hit = '0;
    for (int c = 0; c < NCHAN; c++) begin
      hit[c] = rx_vld[c] &&
        (rx_src[c*ID_W +: ID_W] ==
         (rx_type[c] ? OD_STOP_SRC[c*ID_W +: ID_W]
                     : MD_STOP_SRC[c*ID_W +: ID_W]));
    end
  end

  // Ring forwarding: copy, inject local message, or consume
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_vld <= SEED;
      tx_type <= TYPE_RST;
      tx_src <= {NCHAN{NODEID}};
      tx_pt <= '0;
      ltype <= ~TYPE_RST;
      for (int c = 0; c < NCHAN; c++) cnt[c] <= PT_ONE;
    end else begin
      for (int c = 0; c < NCHAN; c++) begin
        if (hit[c]) begin
          tx_vld[c] <= gen_en;
          if (gen_en) begin
            tx_type[c] <= ltype[c];
            tx_src[c*ID_W +: ID_W] <= NODEID;
            tx_pt[c*PT_W +: PT_W] <= cnt[c];
            cnt[c] <= cnt[c] + PT_ONE;
            ltype[c] <= ~ltype[c];
          end
        end else begin
          tx_vld[c] <= rx_vld[c];
          tx_type[c] <= rx_type[c];
          tx_src[c*ID_W +: ID_W] <= rx_src[c*ID_W +: ID_W];
          tx_pt[c*PT_W +: PT_W] <= rx_pt[c*PT_W +: PT_W];
        end
      end
    end
  end

  // Next slot state: pop clears first, then captures in channel order
  always_comb begin
    err_n = err;
    ecnt_n = err_cnt;
    for (int s = 0; s < NPBUFFS; s++) begin
      sv_n[s] = sv[s];
      if (pop && out_slot == SW'(s)) sv_n[s] = '0;
      for (int w = 0; w < NWATCH; w++) sd_n[s][w] = sd[s][w];
    end
    for (int w = 0; w < NWATCH; w++) begin
      for (int c = 0; c < NCHAN; c++) begin
        if (rx_vld[c] &&
            rx_src[c*ID_W +: ID_W] == NIDS[w*ID_W +: ID_W]) begin
          if (sv_n[rx_pt[c*PT_W +: SW]][w]) begin
            err_n = 1'b1;
            if (ecnt_n != '1) ecnt_n = ecnt_n + E_ONE;
          end else begin
            sv_n[rx_pt[c*PT_W +: SW]][w] = 1'b1;
            sd_n[rx_pt[c*PT_W +: SW]][w] = rx_pt[c*PT_W +: PT_W];
          end
        end
      end
    end
  end

  // Lowest-index full slot in the next state
  always_comb begin
    found = 1'b0;
    sel = '0;
    for (int s = NPBUFFS - 1; s >= 0; s--) begin
      if (&sv_n[s]) begin
        found = 1'b1;
        sel = SW'(s);
      end
    end
  end

  // Slot storage and contention tracking
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err <= 1'b0;
      err_cnt <= '0;
      for (int s = 0; s < NPBUFFS; s++) begin
        sv[s] <= '0;
        for (int w = 0; w < NWATCH; w++) sd[s][w] <= '0;
      end
    end else begin
      err <= err_n;
      err_cnt <= ecnt_n;
      for (int s = 0; s < NPBUFFS; s++) begin
        sv[s] <= sv_n[s];
        for (int w = 0; w < NWATCH; w++) sd[s][w] <= sd_n[s][w];
      end
    end
  end

  // Output record; frozen while the consumer stalls
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_vld <= 1'b0;
      out_slot <= '0;
      out_pt <= '0;
    end else if (!(out_vld && !out_rdy)) begin
      out_vld <= found;
      out_slot <= sel;
      out_pt <= sd_n[sel][0];
    end
  end

endmodule

// File: tb/tb_fft_ring_gather_node.sv
// tb_fft_ring_gather_node: vector table, directed sequences and
// randomized traffic against a behavioural model.
module tb_fft_ring_gather_node;

  localparam logic [95:0] NIDS_P = {32'd8, 32'd6, 32'd4};
  localparam logic [63:0] MD_P = {32'd12, 32'd3};
  localparam logic [63:0] OD_P = {32'd13, 32'd11};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic gen_en = 1'b0;
  logic [1:0] rx_vld = '0;
  logic [1:0] rx_type = '0;
  logic [63:0] rx_src = '0;
  logic [63:0] rx_pt = '0;
  logic [1:0] tx_vld;
  logic [1:0] tx_type;
  logic [63:0] tx_src;
  logic [63:0] tx_pt;
  logic out_vld;
  logic out_rdy = 1'b0;
  logic [0:0] out_slot;
  logic [31:0] out_pt;
  logic err;
  logic [7:0] err_cnt;

  fft_ring_gather_node #(
    .NCHAN(2), .ID_W(32), .PT_W(32), .NODEID(32'd5),
    .NWATCH(3), .NIDS(NIDS_P), .NPBUFFS(2),
    .MD_STOP_SRC(MD_P), .OD_STOP_SRC(OD_P),
    .TYPE_RST(2'b10), .SEED(2'b01), .ERR_W(8)
  ) dut (
    .clk(clk), .rst(rst), .gen_en(gen_en),
    .rx_vld(rx_vld), .rx_type(rx_type),
    .rx_src(rx_src), .rx_pt(rx_pt),
    .tx_vld(tx_vld), .tx_type(tx_type),
    .tx_src(tx_src), .tx_pt(tx_pt),
    .out_vld(out_vld), .out_rdy(out_rdy),
    .out_slot(out_slot), .out_pt(out_pt),
    .err(err), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  int unsigned nids [3] = '{4, 6, 8};
  int unsigned md_stop [2] = '{3, 12};
  int unsigned od_stop [2] = '{11, 13};
  int unsigned pool [9] = '{3, 4, 6, 8, 11, 12, 13, 7, 5};

  int unsigned m_cnt [2];
  bit m_lt [2];
  bit mv [2][3];
  int unsigned md [2][3];
  bit mo_vld;
  int mo_slot;
  int unsigned mo_pt;
  bit m_err;
  int m_ecnt;
  bit mt_vld [2];
  bit mt_type [2];
  int unsigned mt_src [2];
  int unsigned mt_pt [2];

  typedef struct {
    bit g;
    bit v;
    bit t;
    int unsigned s0;
    int unsigned p0;
    bit e_vld;
    bit e_type;
    int unsigned e_src;
    int unsigned e_pt;
  } vec_t;

  vec_t vt [8];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp,
               $time);
    end
  endtask

  task automatic model_reset();
    mt_vld = '{1'b1, 1'b0};
    mt_type = '{1'b0, 1'b1};
    m_lt = '{1'b1, 1'b0};
    for (int c = 0; c < 2; c++) begin
      mt_src[c] = 5;
      mt_pt[c] = 0;
      m_cnt[c] = 1;
    end
    for (int s = 0; s < 2; s++)
      for (int w = 0; w < 3; w++) begin
        mv[s][w] = 0;
        md[s][w] = 0;
      end
    mo_vld = 0;
    mo_slot = 0;
    mo_pt = 0;
    m_err = 0;
    m_ecnt = 0;
  endtask

  task automatic model_step();
    bit pop;
    int ps;
    int s;
    bit full;
    int unsigned src, pt, stop;
    pop = mo_vld && out_rdy;
    ps = mo_slot;
    for (int c = 0; c < 2; c++) begin
      src = rx_src[c*32 +: 32];
      pt = rx_pt[c*32 +: 32];
      stop = rx_type[c] ? od_stop[c] : md_stop[c];
      if (!rx_vld[c]) mt_vld[c] = 0;
      else if (src != stop) begin
        mt_vld[c] = 1;
        mt_type[c] = rx_type[c];
        mt_src[c] = src;
        mt_pt[c] = pt;
      end else if (gen_en) begin
        mt_vld[c] = 1;
        mt_type[c] = m_lt[c];
        mt_src[c] = 5;
        mt_pt[c] = m_cnt[c];
        m_cnt[c] = m_cnt[c] + 1;
        m_lt[c] = !m_lt[c];
      end else mt_vld[c] = 0;
    end
    if (pop) for (int w = 0; w < 3; w++) mv[ps][w] = 0;
    for (int c = 0; c < 2; c++) begin
      src = rx_src[c*32 +: 32];
      pt = rx_pt[c*32 +: 32];
      for (int w = 0; w < 3; w++) begin
        if (rx_vld[c] && src == nids[w]) begin
          s = int'(pt % 2);
          if (mv[s][w]) begin
            m_err = 1;
            if (m_ecnt < 255) m_ecnt++;
          end else begin
            mv[s][w] = 1;
            md[s][w] = pt;
          end
        end
      end
    end
    if (!(mo_vld && !out_rdy)) begin
      mo_vld = 0;
      for (int k = 1; k >= 0; k--) begin
        full = mv[k][0] && mv[k][1] && mv[k][2];
        if (full) begin
          mo_vld = 1;
          mo_slot = k;
        end
      end
      if (mo_vld) mo_pt = md[mo_slot][0];
    end
  endtask

  task automatic check_all();
    for (int c = 0; c < 2; c++) begin
      chk($sformatf("tx_vld%0d", c), tx_vld[c], mt_vld[c]);
      if (mt_vld[c]) begin
        chk($sformatf("tx_type%0d", c), tx_type[c], mt_type[c]);
        chk($sformatf("tx_src%0d", c), tx_src[c*32 +: 32], mt_src[c]);
        chk($sformatf("tx_pt%0d", c), tx_pt[c*32 +: 32], mt_pt[c]);
      end
    end
    chk("out_vld", out_vld, mo_vld);
    if (mo_vld) begin
      chk("out_slot", out_slot, mo_slot);
      chk("out_pt", out_pt, mo_pt);
    end
    chk("err", err, m_err);
    chk("err_cnt", err_cnt, m_ecnt);
  endtask

  task automatic drive(input bit g, input bit [1:0] v, input bit [1:0] t,
                       input int unsigned s0, input int unsigned s1,
                       input int unsigned p0, input int unsigned p1,
                       input bit r);
    gen_en = g;
    rx_vld = v;
    rx_type = t;
    rx_src = {s1, s0};
    rx_pt = {p1, p0};
    out_rdy = r;
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic idle(input bit r);
    drive(0, 2'b00, 2'b00, 0, 0, 0, 0, r);
    cycle();
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    check_all();
  endtask

  task automatic rand_cycle();
    drive(1'($urandom), 2'($urandom), 2'($urandom),
          pool[$urandom_range(0, 8)], pool[$urandom_range(0, 8)],
          $urandom_range(0, 7), $urandom_range(0, 7),
          1'($urandom));
    cycle();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_tx_vld"}, tx_vld, 2'b01);
    chk({tag, "_tx_type"}, tx_type, 2'b10);
    chk({tag, "_tx_src"}, tx_src, {32'd5, 32'd5});
    chk({tag, "_tx_pt"}, tx_pt, 64'd0);
    chk({tag, "_out_vld"}, out_vld, 1'b0);
    chk({tag, "_err"}, err, 1'b0);
    chk({tag, "_err_cnt"}, err_cnt, 8'd0);
  endtask

  initial begin
    vt[0] = '{0, 1, 0, 7, 9, 1, 0, 7, 9};
    vt[1] = '{1, 1, 0, 3, 0, 1, 1, 5, 1};
    vt[2] = '{1, 1, 0, 3, 0, 1, 0, 5, 2};
    vt[3] = '{0, 1, 0, 3, 0, 0, 0, 0, 0};
    vt[4] = '{1, 1, 0, 3, 0, 1, 1, 5, 3};
    vt[5] = '{1, 0, 0, 3, 0, 0, 0, 0, 0};
    vt[6] = '{1, 1, 1, 11, 0, 1, 0, 5, 4};
    vt[7] = '{1, 1, 1, 3, 8, 1, 1, 3, 8};

    repeat (2) @(negedge clk);
    apply_reset();
    chk_reset_vals("rst");

    for (int i = 0; i < 8; i++) begin
      drive(vt[i].g, {1'b0, vt[i].v}, {1'b0, vt[i].t},
            vt[i].s0, 0, vt[i].p0, 0, 0);
      cycle();
      chk($sformatf("vec%0d_vld", i), tx_vld[0], vt[i].e_vld);
      if (vt[i].e_vld) begin
        chk($sformatf("vec%0d_type", i), tx_type[0], vt[i].e_type);
        chk($sformatf("vec%0d_src", i), tx_src[31:0], vt[i].e_src);
        chk($sformatf("vec%0d_pt", i), tx_pt[31:0], vt[i].e_pt);
      end
    end

    apply_reset();
    drive(0, 2'b01, 2'b00, 4, 0, 6, 0, 0);
    cycle();
    chk("fill1_vld", out_vld, 1'b0);
    drive(0, 2'b10, 2'b00, 0, 6, 0, 6, 0);
    cycle();
    chk("fill2_vld", out_vld, 1'b0);
    drive(0, 2'b01, 2'b00, 8, 0, 6, 0, 0);
    cycle();
    chk("full_vld", out_vld, 1'b1);
    chk("full_slot", out_slot, 1'b0);
    chk("full_pt", out_pt, 32'd6);
    for (int i = 0; i < 3; i++) begin
      idle(0);
      chk("hold_vld", out_vld, 1'b1);
      chk("hold_slot", out_slot, 1'b0);
      chk("hold_pt", out_pt, 32'd6);
    end
    idle(1);
    chk("pop_vld", out_vld, 1'b0);

    drive(0, 2'b01, 2'b00, 4, 0, 2, 0, 0);
    cycle();
    chk("cap_err", err, 1'b0);
    drive(0, 2'b01, 2'b00, 4, 0, 4, 0, 0);
    cycle();
    chk("dup_err", err, 1'b1);
    chk("dup_cnt", err_cnt, 8'd1);
    drive(0, 2'b11, 2'b00, 4, 4, 3, 5, 0);
    cycle();
    chk("same_cyc_cnt", err_cnt, 8'd2);
    drive(0, 2'b11, 2'b00, 6, 8, 0, 2, 0);
    cycle();
    chk("kept_vld", out_vld, 1'b1);
    chk("kept_slot", out_slot, 1'b0);
    chk("kept_pt", out_pt, 32'd2);
    idle(1);
    drive(0, 2'b11, 2'b00, 6, 8, 1, 1, 0);
    cycle();
    chk("win_vld", out_vld, 1'b1);
    chk("win_slot", out_slot, 1'b1);
    chk("win_pt", out_pt, 32'd3);

    drive(0, 2'b01, 2'b00, 4, 0, 5, 0, 1);
    cycle();
    chk("popcap_vld", out_vld, 1'b0);
    chk("popcap_cnt", err_cnt, 8'd2);
    drive(0, 2'b11, 2'b00, 6, 8, 1, 1, 0);
    cycle();
    chk("popcap_full", out_vld, 1'b1);
    chk("popcap_slot", out_slot, 1'b1);
    chk("popcap_pt", out_pt, 32'd5);
    chk("popcap_cnt2", err_cnt, 8'd2);
    idle(1);

    repeat (400) rand_cycle();

    drive(1, 2'b11, 2'b00, 4, 6, 1, 1, 0);
    #2 rst = 1'b1;
    #1 chk_reset_vals("async");
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_all();
    repeat (100) rand_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fft_ring_gather_node.md
Name: fft_ring_gather_node

Overview:
Parametrised next-generation FFT message-ring node. Forwards NCHAN independent ring channels, and each channel carries an explicit valid bit. On a stop-source hit the node terminates the arriving message and injects its own, gated by an enable input. It gathers points from NWATCH watched node IDs into NPBUFFS slot buffers and issues a completed-slot record on a valid/ready output. Contention is reported through a sticky flag and a counter instead of halting simulation.

Parameters:
NCHAN, 2, number of ring channels (ch0 = forward, ch1 = reverse, more allowed)
ID_W, 32, node-id field width
PT_W, 32, FFT point-count field width
NODEID, 0, this node's ID
NWATCH, 3, number of watched node IDs (>=1)
NIDS, all 0, [NWATCH][ID_W] watched IDs
NPBUFFS, 2, gather slots; power of 2, >=2
MD_STOP_SRC, all 0, [NCHAN][ID_W] stop source for msg_type 0 (MD)
OD_STOP_SRC, all 0, [NCHAN][ID_W] stop source for msg_type 1 (OD)
TYPE_RST, 0, [NCHAN] 1-bit reset msg type per channel
SEED, 0, [NCHAN] 1 = channel emits a valid seed message out of reset
ERR_W, 8, contention counter width

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
gen_en  in  1  1 = replace terminated messages with local message
rx_vld  in  NCHAN  per-channel message valid
rx_type  in  NCHAN  per-channel msg type (0 MD, 1 OD)
rx_src  in  NCHAN*ID_W  per-channel source id
rx_pt  in  NCHAN*PT_W  per-channel point
tx_vld  out  NCHAN  registered valid
tx_type  out  NCHAN  registered type
tx_src  out  NCHAN*ID_W  registered source id
tx_pt  out  NCHAN*PT_W  registered point
out_vld  out  1  completed slot available
out_rdy  in  1  consumer accepts
out_slot  out  clog2(NPBUFFS)  slot index
out_pt  out  PT_W  point stored in watch entry 0 of slot
err  out  1  sticky contention flag
err_cnt  out  ERR_W  saturating contention count

Behaviour:
- Reset (async assert, sync release): tx_vld[c]=SEED[c]; tx_type[c]=TYPE_RST[c]; tx_src[c]=NODEID; tx_pt[c]=0. Local cnt[c]=1, local type[c]=~TYPE_RST[c]. All slot valids=0, data=0. out_vld=0, err=0, err_cnt=0.
- Stop hit on ch c: rx_vld[c] && rx_src[c] == (rx_type[c] ? OD_STOP_SRC[c] : MD_STOP_SRC[c]).
- Forwarding, latency 1 cycle per channel:
  - No valid: tx_vld=0.
  - Valid, no hit: copy rx to tx.
  - Hit with gen_en=1: tx = {1, type[c], NODEID, cnt[c]}; next cycle cnt[c]+1 (wraps mod 2^PT_W) and type[c] toggles.
  - Hit with gen_en=0: tx_vld=0; cnt and type unchanged (message consumed).
- Capture:
  - For each channel with rx_vld and rx_src==NIDS[w]: slot s = rx_pt[PT_W-1:0] mod NPBUFFS; write entry (s,w) = rx_pt and set valid.
  - Captured messages are still forwarded/terminated as above.
- Slot full: all NWATCH valids set.
- Output:
  - out_vld=1 when any slot is full; out_slot = lowest-index full slot, out_pt its entry 0. Registered: the slot becomes full in cycle N, out_vld is seen in cycle N+1.
  - out_vld && out_rdy pops the slot (clears all its valids).
  - out_slot/out_pt hold stable while out_vld && !out_rdy.
- Contention:
  - Capture to an entry already valid in a slot not popped this cycle: new data dropped, err=1, err_cnt+1 (saturates at all-ones).
  - Two channels hitting the same (s,w) in one cycle: lowest channel wins, each loser counts one contention.
- Capture into a slot popped the same cycle: clear applies first, new capture is written (valid=1), no error.
- Multiple contentions in one cycle add their count, saturating.
- rst asserted mid-operation: all state returns to reset values immediately; in-flight messages are lost.

Test Plan:
1. Reset with SEED=2'b01, TYPE_RST=2'b10, NODEID=5 -> tx_vld=01, tx_src both 5, tx_pt 0, tx_type=10, out_vld=0, err=0.
2. ch0 rx {vld,type0,src=7,pt=9}, MD_STOP_SRC[0]=3 -> next cycle tx ch0 = {1,0,7,9}; cnt[0] stays 1.
3. ch0 stop hit (src=3,type0), gen_en=1, twice -> tx_pt 1 then 2, tx_type alternates 1,0, tx_src=NODEID. Repeat with gen_en=0 -> tx_vld[0]=0 and cnt unchanged.
4. NIDS={4,6,8}, NPBUFFS=2: pts 6 from src 4 (ch0), 6 from src 6 (ch1), 6 from src 8 (ch0) -> out_vld=1 one cycle after the third capture, out_slot=0, out_pt=6; hold out_rdy=0 for 3 cycles (stable), then out_rdy=1 -> slot cleared, out_vld=0.
5. Src 4 pt 2, then src 4 pt 4 before slot 0 fills -> err=1, err_cnt=1, stored entry still 2. Same-cycle ch0/ch1 both src 6 pt 3 -> ch0 value kept, err_cnt=2.
6. Slot 1 full with out_rdy=1 while src 4 pt 5 arrives the same cycle -> pop happens, entry (1,0) valid with 5, no error. Assert rst mid-stream -> all outputs return to reset values asynchronously.
